// File: rtl/stream_phase_profiler_if.sv
// Snooped ready/valid bundle: NUM_IN write-side and NUM_OUT read-side streams.
// The source side drives through master; the profiler only observes through slave.
interface stream_phase_profiler_if #(
  parameter int DATA_W  = 17,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2
);
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;

  modport master (
    output in_data, in_valid, in_ready,
    output out_data, out_valid, out_ready
  );

  modport slave (
    input in_data, in_valid, in_ready,
    input out_data, out_valid, out_ready
  );
endinterface

// File: rtl/stream_phase_profiler.sv
// Passive WRITE/GAP/READ phase profiler; all outputs registered, one cycle after the sampled event.
// Pure observer: never touches ready or valid, so it adds no backpressure.
module stream_phase_profiler #(
  parameter int                 DATA_W     = 17,
  parameter int                 NUM_IN     = 2,
  parameter int                 NUM_OUT    = 2,
  parameter int                 CNT_W      = 32,
  parameter logic [DATA_W-1:0]  DONE_TOKEN = 17'h10100,
  parameter int                 GAP_CYCLES = 0,
  parameter logic [NUM_IN-1:0]  TRIG_MASK  = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   flush,
  stream_phase_profiler_if.slave mon,
  output logic [2:0]             phase,
  output logic [CNT_W-1:0]       write_cycles,
  output logic [CNT_W-1:0]       read_cycles,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic                   saturated,
  output logic                   done
);

  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_GAP   = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_q, wr_d, rd_q, rd_d, st_q, st_d;
  logic [GW-1:0]      gap_q, gap_d, gap_nxt;
  logic [NUM_IN-1:0]  in_done_q, in_done_d, trig_q, trig_d;
  logic [NUM_OUT-1:0] out_done_q, out_done_d;
  logic               sat_q, sat_d, done_q, done_d;

  logic [NUM_IN-1:0]  in_dhit, in_done_now, trig_now;
  logic [NUM_OUT-1:0] out_dhit, out_done_now;
  logic               trig_ok, stall_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Current-cycle events are folded into the stickies so exit decisions see them.
  always_comb begin
    in_dhit  = '0;
    out_dhit = '0;
    for (int i = 0; i < NUM_IN; i++)
      in_dhit[i] = mon.in_valid[i] && mon.in_ready[i] &&
                   (mon.in_data[i*DATA_W +: DATA_W] == DONE_TOKEN);
    for (int j = 0; j < NUM_OUT; j++)
      out_dhit[j] = mon.out_valid[j] && mon.out_ready[j] &&
                    (mon.out_data[j*DATA_W +: DATA_W] == DONE_TOKEN);
    in_done_now  = in_done_q | in_dhit;
    out_done_now = out_done_q | out_dhit;
    trig_now     = trig_q | (mon.in_valid & TRIG_MASK);
    trig_ok      = &(trig_now | ~TRIG_MASK);
    stall_now    = |(mon.out_valid & ~mon.out_ready);
    gap_nxt      = (gap_q == '0) ? '0 : gap_q - 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    st_d       = st_q;
    gap_d      = gap_q;
    in_done_d  = in_done_q;
    out_done_d = out_done_q;
    trig_d     = trig_q;
    sat_d      = sat_q;
    done_d     = done_q;
    if (flush) begin
      state_d    = S_IDLE;
      wr_d       = '0;
      rd_d       = '0;
      st_d       = '0;
      gap_d      = '0;
      in_done_d  = '0;
      out_done_d = '0;
      trig_d     = '0;
      sat_d      = 1'b0;
      done_d     = 1'b0;
    end else if (clk_en) begin
      in_done_d  = in_done_now;
      out_done_d = out_done_now;
      trig_d     = trig_now;
      case (state_q)
        S_IDLE: begin
          if (|mon.in_valid) begin
            state_d = S_WRITE;
            wr_d    = CNT_W'(1);
          end
        end
        S_WRITE: begin
          wr_d = sat_inc(wr_q);
          if (&in_done_now) begin
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = GW'(GAP_CYCLES);
            end else if (trig_ok) begin
              state_d = S_READ;
              rd_d    = CNT_W'(1);
            end else begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end
        S_GAP: begin
          // Counter parks at zero while waiting for the trigger inputs.
          gap_d = gap_nxt;
          if (gap_nxt == '0 && trig_ok) begin
            state_d = S_READ;
            rd_d    = CNT_W'(1);
          end
        end
        S_READ: begin
          rd_d = sat_inc(rd_q);
          if (stall_now) st_d = sat_inc(st_q);
          if (&out_done_now) state_d = S_DONE;
        end
        default: ;
      endcase
      sat_d  = sat_q | (&wr_d) | (&rd_d) | (&st_d);
      done_d = (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      st_q       <= '0;
      gap_q      <= '0;
      in_done_q  <= '0;
      out_done_q <= '0;
      trig_q     <= '0;
      sat_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      st_q       <= st_d;
      gap_q      <= gap_d;
      in_done_q  <= in_done_d;
      out_done_q <= out_done_d;
      trig_q     <= trig_d;
      sat_q      <= sat_d;
      done_q     <= done_d;
    end
  end

  assign phase        = state_q;
  assign write_cycles = wr_q;
  assign read_cycles  = rd_q;
  assign stall_cycles = st_q;
  assign saturated    = sat_q;
  assign done         = done_q;

endmodule

// File: tb/tb_stream_phase_profiler.sv
// Scoreboarded bench for stream_phase_profiler: three instances cover the default,
// single-stream and narrow-counter/gap configurations.
module tb_stream_phase_profiler;

  localparam logic [16:0] DT = 17'h10100;

  typedef struct packed {
    logic [31:0] wr;
    logic [31:0] rd;
    logic [31:0] st;
    logic        sat;
  } exp_t;

  logic clk, rst_n;
  logic en_a, en_b, en_c, fl_a, fl_b, fl_c;

  logic [2:0]  a_ph, b_ph, c_ph;
  logic [31:0] a_wr, a_rd, a_st, b_wr, b_rd, b_st;
  logic [3:0]  c_wr, c_rd, c_st;
  logic        a_sat, b_sat, c_sat, a_done, b_done, c_done;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  stream_phase_profiler_if #(.DATA_W(17), .NUM_IN(2), .NUM_OUT(2)) ia();
  stream_phase_profiler_if #(.DATA_W(17), .NUM_IN(1), .NUM_OUT(1)) ib();
  stream_phase_profiler_if #(.DATA_W(17), .NUM_IN(1), .NUM_OUT(1)) ic();

  stream_phase_profiler #(.DATA_W(17), .NUM_IN(2), .NUM_OUT(2), .CNT_W(32),
    .DONE_TOKEN(DT), .GAP_CYCLES(0), .TRIG_MASK(2'b10)) ua (
    .clk(clk), .rst_n(rst_n), .clk_en(en_a), .flush(fl_a), .mon(ia),
    .phase(a_ph), .write_cycles(a_wr), .read_cycles(a_rd), .stall_cycles(a_st),
    .saturated(a_sat), .done(a_done));

  stream_phase_profiler #(.DATA_W(17), .NUM_IN(1), .NUM_OUT(1), .CNT_W(32),
    .DONE_TOKEN(DT), .GAP_CYCLES(0), .TRIG_MASK(1'b0)) ub (
    .clk(clk), .rst_n(rst_n), .clk_en(en_b), .flush(fl_b), .mon(ib),
    .phase(b_ph), .write_cycles(b_wr), .read_cycles(b_rd), .stall_cycles(b_st),
    .saturated(b_sat), .done(b_done));

  stream_phase_profiler #(.DATA_W(17), .NUM_IN(1), .NUM_OUT(1), .CNT_W(4),
    .DONE_TOKEN(DT), .GAP_CYCLES(3), .TRIG_MASK(1'b1)) uc (
    .clk(clk), .rst_n(rst_n), .clk_en(en_c), .flush(fl_c), .mon(ic),
    .phase(c_ph), .write_cycles(c_wr), .read_cycles(c_rd), .stall_cycles(c_st),
    .saturated(c_sat), .done(c_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int wr, input int rd, input int st, input logic sat);
    exp_t e;
    e.wr = wr; e.rd = rd; e.st = st; e.sat = sat;
    case (k)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Monitor: every rising done is a finished tile; pop and compare its result.
  logic [2:0] dn, dn_prev = '0;
  assign dn = {c_done, b_done, a_done};

  always @(negedge clk) begin
    exp_t e;
    logic have;
    logic [31:0] aw, ar, as_;
    logic asat;
    for (int k = 0; k < 3; k++) begin
      if (dn[k] && !dn_prev[k]) begin
        have = 1'b0;
        e = '0;
        case (k)
          0: begin if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
                   aw = a_wr; ar = a_rd; as_ = a_st; asat = a_sat; end
          1: begin if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
                   aw = b_wr; ar = b_rd; as_ = b_st; asat = b_sat; end
          default: begin if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
                   aw = 32'(c_wr); ar = 32'(c_rd); as_ = 32'(c_st); asat = c_sat; end
        endcase
        if (!have) chk($sformatf("dut%0d_unexpected_done", k), 32'd1, 32'd0);
        else begin
          chk($sformatf("dut%0d_write_cycles", k), aw, e.wr);
          chk($sformatf("dut%0d_read_cycles", k), ar, e.rd);
          chk($sformatf("dut%0d_stall_cycles", k), as_, e.st);
          chk($sformatf("dut%0d_saturated", k), 32'(asat), 32'(e.sat));
        end
      end
    end
    dn_prev = dn;
  end

  task automatic clear_all();
    ia.in_data = '0; ia.in_valid = '0; ia.in_ready = '0;
    ia.out_data = '0; ia.out_valid = '0; ia.out_ready = '0;
    ib.in_data = '0; ib.in_valid = '0; ib.in_ready = '0;
    ib.out_data = '0; ib.out_valid = '0; ib.out_ready = '0;
    ic.in_data = '0; ic.in_valid = '0; ic.in_ready = '0;
    ic.out_data = '0; ic.out_valid = '0; ic.out_ready = '0;
  endtask

  initial begin
    int gcnt;
    clear_all();
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    fl_a = 1'b0; fl_b = 1'b0; fl_c = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    chk("rst_phase", 32'(a_ph), 32'd0);
    chk("rst_write", a_wr, 32'd0);
    chk("rst_read", a_rd, 32'd0);
    chk("rst_stall", a_st, 32'd0);
    chk("rst_sat", 32'(a_sat), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Single stream: 5,6,7,DONE gives 4 write cycles and READ right after.
    push(1, 4, 3, 0, 1'b0);
    ib.in_ready = 1'b1; ib.in_valid = 1'b1;
    ib.in_data = 17'd5; cyc(1);
    ib.in_data = 17'd6; cyc(1);
    ib.in_data = 17'd7; cyc(1);
    ib.in_data = DT;    cyc(1);
    ib.in_valid = 1'b0;
    chk("t1_phase_read", 32'(b_ph), 32'd3);
    chk("t1_write_cycles", b_wr, 32'd4);
    ib.out_ready = 1'b1; ib.out_valid = 1'b1;
    ib.out_data = 17'd9; cyc(1);
    ib.out_data = DT;    cyc(1);
    ib.out_valid = 1'b0;
    cyc(1);
    fl_b = 1'b1; cyc(1); fl_b = 1'b0;
    chk("b_flush_phase", 32'(b_ph), 32'd0);

    // Output DONE latched while IDLE makes READ last a single cycle.
    push(1, 2, 2, 0, 1'b0);
    ib.out_valid = 1'b1; ib.out_data = DT; cyc(1);
    ib.out_valid = 1'b0;
    ib.in_valid = 1'b1; ib.in_data = DT; cyc(1);
    ib.in_valid = 1'b0;
    cyc(3);

    // Three GAP cycles between WRITE exit and READ entry.
    push(2, 2, 2, 0, 1'b0);
    ic.in_ready = 1'b1; ic.in_valid = 1'b1; ic.in_data = DT; cyc(1);
    ic.in_valid = 1'b0; cyc(1);
    gcnt = 0;
    for (int i = 0; i < 20 && c_ph == 3'd2; i++) begin gcnt++; cyc(1); end
    chk("t2_gap_len", 32'(gcnt), 32'd3);
    chk("t2_phase_read", 32'(c_ph), 32'd3);
    ic.out_ready = 1'b1; ic.out_valid = 1'b1; ic.out_data = DT; cyc(1);
    ic.out_valid = 1'b0;
    cyc(1);
    fl_c = 1'b1; cyc(1); fl_c = 1'b0;

    // Narrow counters: a 20-cycle WRITE saturates at 15.
    push(2, 15, 2, 0, 1'b1);
    ic.in_valid = 1'b1; ic.in_data = 17'd1; cyc(19);
    ic.in_data = DT; cyc(1);
    ic.in_valid = 1'b0;
    chk("t5_sat_after_write", 32'(c_sat), 32'd1);
    for (int i = 0; i < 20 && c_ph != 3'd3; i++) cyc(1);
    chk("t5_reach_read", 32'(c_ph), 32'd3);
    ic.out_valid = 1'b1; ic.out_data = DT; cyc(1);
    ic.out_valid = 1'b0;
    cyc(2);

    // Trigger input first raised 10 cycles after channel 0's DONE, then stalls in READ.
    push(0, 13, 7, 4, 1'b0);
    ia.in_ready = 2'b11;
    ia.in_valid = 2'b01; ia.in_data[0 +: 17] = 17'd3; cyc(1);
    ia.in_data[0 +: 17] = DT; cyc(1);
    ia.in_valid = 2'b00; cyc(10);
    chk("t3_held_in_write", 32'(a_ph), 32'd1);
    ia.in_valid = 2'b10; ia.in_data[17 +: 17] = DT; cyc(1);
    ia.in_valid = 2'b00;
    chk("t3_read_entry", 32'(a_ph), 32'd3);
    ia.out_valid = 2'b01; ia.out_ready = 2'b00; ia.out_data[0 +: 17] = 17'd4; cyc(4);
    ia.out_ready = 2'b01; ia.out_data[0 +: 17] = DT; cyc(1);
    ia.out_valid = 2'b10; ia.out_ready = 2'b10; ia.out_data[17 +: 17] = DT; cyc(1);
    ia.out_valid = 2'b00;
    cyc(1);
    fl_a = 1'b1; cyc(1); fl_a = 1'b0;

    // Flush mid-READ.
    ia.in_valid = 2'b11; ia.in_data = {DT, DT}; cyc(1);
    ia.in_valid = 2'b00; cyc(2);
    fl_a = 1'b1; cyc(1); fl_a = 1'b0;
    chk("t6_flush_phase", 32'(a_ph), 32'd0);
    chk("t6_flush_write", a_wr, 32'd0);
    chk("t6_flush_read", a_rd, 32'd0);
    chk("t6_flush_done", 32'(a_done), 32'd0);

    // clk_en low for 5 cycles ignores DONE handshakes; then async reset mid-WRITE.
    ia.in_valid = 2'b01; ia.in_data = {17'd0, 17'd3}; cyc(2);
    en_a = 1'b0; ia.in_valid = 2'b11; ia.in_data = {DT, DT}; cyc(5);
    chk("t6_en_write_hold", a_wr, 32'd2);
    chk("t6_en_phase_hold", 32'(a_ph), 32'd1);
    en_a = 1'b1; ia.in_valid = 2'b01; ia.in_data = {17'd0, 17'd3}; cyc(1);
    chk("t6_write_resume", a_wr, 32'd3);
    rst_n = 1'b0; clear_all(); #2;
    chk("t6_rst_phase", 32'(a_ph), 32'd0);
    chk("t6_rst_write", a_wr, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Gated stall window in READ contributes nothing.
    push(0, 2, 3, 1, 1'b0);
    ia.in_ready = 2'b11; ia.in_valid = 2'b11; ia.in_data = {DT, DT}; cyc(1);
    ia.in_valid = 2'b00; cyc(1);
    ia.out_valid = 2'b01; ia.out_ready = 2'b00; ia.out_data[0 +: 17] = 17'd4;
    en_a = 1'b0; cyc(5);
    en_a = 1'b1; cyc(1);
    ia.out_valid = 2'b11; ia.out_ready = 2'b11; ia.out_data = {DT, DT}; cyc(1);
    ia.out_valid = 2'b00;
    cyc(3);

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    chk("qc_drained", 32'(qc.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
